// File: rtl/y86_mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch reads and memory-stage reads/writes.
// Optional performance counters are enabled with the Y86_ARB_PERF_EN macro.
module y86_mem_port_arbiter #(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned DATA_W       = 64,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic [DATA_W-1:0] f_rdata,
   output logic              f_ready,
   output logic              f_err,
   output logic              f_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              d_err,
   output logic              d_stall,
   output logic              mem_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_err
`ifdef Y86_ARB_PERF_EN
   ,
   output logic [31:0]       perf_f_grants,
   output logic [31:0]       perf_d_grants,
   output logic [31:0]       perf_conflicts
`endif
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] BUSY_F = 2'd1;
   localparam logic [1:0] BUSY_D = 2'd2;
   localparam logic [1:0] DONE   = 2'd3;

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   logic [1:0] state;
   logic [3:0] starve_cnt;
   logic       starved;
   logic       grant_d;
   logic       grant_f;
   logic       in_idle;
   logic [DATA_W-1:0] ack_rdata;

   assign in_idle = (state == IDLE);
   assign starved = (starve_cnt == STARVE_MAX);
   assign grant_d = in_idle && d_req && !starved;
   assign grant_f = in_idle && !grant_d && f_req;

   // Writes and faulted accesses return zero rather than whatever memory drove.
   assign ack_rdata = (mem_we || mem_err) ? '0 : mem_rdata;

   assign f_stall = f_req && !f_ready;
   assign d_stall = d_req && !d_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_valid  <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         f_ready    <= 1'b0;
         f_err      <= 1'b0;
         f_rdata    <= '0;
         d_ready    <= 1'b0;
         d_err      <= 1'b0;
         d_rdata    <= '0;
      end else begin
         f_ready <= 1'b0;
         d_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  state      <= BUSY_D;
                  mem_valid  <= 1'b1;
                  mem_we     <= d_we;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  starve_cnt <= f_req ? starve_cnt + 4'd1 : '0;
               end else if (grant_f) begin
                  state      <= BUSY_F;
                  mem_valid  <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= f_addr;
                  mem_wdata  <= '0;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY_F: begin
               if (mem_ack) begin
                  state     <= DONE;
                  mem_valid <= 1'b0;
                  f_ready   <= 1'b1;
                  f_err     <= mem_err;
                  f_rdata   <= ack_rdata;
               end
            end
            BUSY_D: begin
               if (mem_ack) begin
                  state     <= DONE;
                  mem_valid <= 1'b0;
                  d_ready   <= 1'b1;
                  d_err     <= mem_err;
                  d_rdata   <= ack_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef Y86_ARB_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_f_grants  <= '0;
         perf_d_grants  <= '0;
         perf_conflicts <= '0;
      end else begin
         if (grant_f && (perf_f_grants != '1))
            perf_f_grants <= perf_f_grants + 32'd1;
         if (grant_d && (perf_d_grants != '1))
            perf_d_grants <= perf_d_grants + 32'd1;
         if (in_idle && f_req && d_req && (perf_conflicts != '1))
            perf_conflicts <= perf_conflicts + 32'd1;
      end
   end
`endif

endmodule

// File: doc/y86_mem_port_arbiter.md
Name: y86_mem_port_arbiter

Overview:
Shares one single-port unified memory between the pipeline's fetch stage (instruction reads) and memory stage (data reads/writes). Sits between the fetch/memorywrite stages and the memory model. Sequences one transaction at a time over a valid/ack handshake and returns data and per-stage stall signals. The pipeline control logic uses the stall signals to freeze F/D or M/W.

Parameters:
ADDR_W, 64, address width of both requesters and memory port
DATA_W, 64, data width (fetch reads a full DATA_W line; byte extraction stays in fetch)
STARVE_LIMIT, 4, consecutive lost arbitrations after which fetch is forced to win (1..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
f_req  in  1  fetch read request; held until f_ready
f_addr  in  ADDR_W  fetch address
f_rdata  out  DATA_W  fetch read data, valid with f_ready
f_ready  out  1  one-cycle completion pulse for fetch
f_err  out  1  error flag, valid with f_ready
f_stall  out  1  f_req && !f_ready
d_req  in  1  memory-stage request; held until d_ready
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read data, valid with d_ready
d_ready  out  1  one-cycle completion pulse for memory stage
d_err  out  1  error flag, valid with d_ready
d_stall  out  1  d_req && !d_ready
mem_valid  out  1  request to memory, held until mem_ack
mem_we  out  1  write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion, one cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack
mem_err  in  1  bad-address flag, valid with mem_ack

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_valid, mem_we, f_ready, d_ready, f_err, d_err = 0; mem_addr, mem_wdata, f_rdata, d_rdata = 0; starve counter = 0. Stall outputs follow their combinational definition.
- FSM states: IDLE, BUSY_F, BUSY_D, DONE.
- IDLE: d_req and fetch not starved -> BUSY_D. Else f_req -> BUSY_F. Else stay. Fetch is starved when starve counter == STARVE_LIMIT.
- On the IDLE->BUSY_x edge, register mem_addr, mem_we (0 for fetch, d_we for data) and mem_wdata, and assert mem_valid.
- BUSY_x: hold mem_valid and all mem_* stable until mem_ack. On mem_ack:
  - Deassert mem_valid.
  - Register rdata to the owner (0 for writes or when mem_err=1).
  - Set the owner's err = mem_err.
  - Pulse the owner's ready for exactly one cycle.
  - Go to DONE.
- DONE: one turnaround cycle; ready deasserts; -> IDLE. Requester may drop or re-present req in this cycle.
- Latency: req sampled at edge 0, mem_valid high after edge 0, ack at cycle k, ready high after edge k. Minimum req-to-ready is 2 cycles; back-to-back issue rate is one transaction per 3 cycles plus memory wait.
- Starve counter:
  - Increments, saturating at STARVE_LIMIT, when IDLE grants data while f_req=1.
  - Clears when fetch is granted or when f_req=0 in IDLE.
- Simultaneous f_req and d_req: data wins unless fetch is starved. This keeps the older instruction progressing.
- If req drops mid-transaction (protocol violation), the transaction still completes and the ready pulse is still issued.
- A mem_ack while in IDLE or DONE is ignored.
- rst_n asserted mid-transaction aborts it immediately: mem_valid drops asynchronously and no ready is issued. Memory must discard the outstanding request.
- Ready/err outputs are registered. Stall outputs are combinational.

Optional Feature:
Macro Y86_ARB_PERF_EN.
- Defined: adds outputs perf_f_grants[31:0], perf_d_grants[31:0] and perf_conflicts[31:0].
  - The conflicts counter counts IDLE cycles with f_req && d_req.
  - All three are saturating at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist. Core behaviour is identical in both cases.

Test Plan:
1. Fetch-only read: f_req=1, f_addr=0x40, memory acks 1 cycle after mem_valid with rdata=0x30F4_0000_0000_0000 -> mem_we=0, mem_addr=0x40, f_ready pulses 1 cycle with f_rdata equal to that rdata, f_err=0, f_stall high until that cycle.
2. Conflict: f_req and d_req (write, addr 0x100, wdata 0xDEAD) rise together -> data served first (mem_we=1, mem_addr=0x100). Then after DONE, fetch served. d_ready precedes f_ready by 3+wait cycles.
3. Starvation: d_req held high continuously with fetch requesting, STARVE_LIMIT=4 -> exactly 4 data grants, then a fetch grant, then the counter clears.
4. Error: d_req read at 0xFFFF_FFFF_FFFF_FFF8, memory acks with mem_err=1, rdata=0x55 -> d_ready=1, d_err=1, d_rdata=0.
5. Reset mid-op: assert rst_n=0 while in BUSY_F with mem_valid=1 -> mem_valid=0 immediately, no f_ready. After release, state is IDLE and a new f_req is granted normally.
6. Wait states: memory delays ack by 5 cycles -> mem_addr/mem_wdata/mem_we stay stable for all 5 cycles, exactly one ready pulse. With Y86_ARB_PERF_EN, grant counters increment by exactly 1.
